// File: rtl/exmem_pkg.sv
// Shared widths and field bundles for the EX->MEM pipeline register.
// The control groups are kept as small structs so the top can gate them as a unit.
package exmem_pkg;

  localparam int DEF_PC_W       = 12;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_REG_ADDR_W = 3;

  typedef struct packed {
    logic mem_read_write;
    logic pc_src;
  } exmem_mem_ctrl_t;

  typedef struct packed {
    logic mem_or_alu;
    logic reg_write_signal;
  } exmem_wb_ctrl_t;

  typedef struct packed {
    logic [DEF_PC_W-1:0]       new_branch_pc;
    logic                      zero;
    logic [DEF_DATA_W-1:0]     alu_result;
    logic [DEF_DATA_W-1:0]     data_2;
    logic [DEF_REG_ADDR_W-1:0] reg_write;
    exmem_mem_ctrl_t           mem;
    exmem_wb_ctrl_t            wb;
  } exmem_payload_t;

  // Kill the write-enabling control bits of a slot that holds no instruction.
  function automatic exmem_mem_ctrl_t gate_mem(input exmem_mem_ctrl_t c, input logic vld);
    exmem_mem_ctrl_t r;
    r.mem_read_write = c.mem_read_write & vld;
    r.pc_src         = c.pc_src & vld;
    return r;
  endfunction

endpackage

// File: rtl/exmem_slot.sv
// One pipeline slot: valid bit plus payload register with load/hold/clear.
// Load wins over clear so a slot can hand its entry on and refill in the same edge.
module exmem_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  logic         vld_q;
  logic [W-1:0] dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (load_i) begin
      vld_q <= 1'b1;
      dat_q <= dat_i;
    end else if (clear_i) begin
      vld_q <= 1'b0;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/exmem_pipe.sv
// Elastic EX->MEM register chain of DEPTH slots: DEPTH-cycle latency, 1/cycle throughput.
// Combinational ready chain lets bubbles collapse under stall; in_ready drops only when all slots are full.
module exmem_pipe
  import exmem_pkg::*;
#(
  parameter int PC_W       = DEF_PC_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_W-1:0]              in_new_branch_pc,
  input  logic                         in_zero,
  input  logic [DATA_W-1:0]            in_alu_result,
  input  logic [DATA_W-1:0]            in_data_2,
  input  logic [REG_ADDR_W-1:0]        in_reg_write,
  input  logic                         in_MEM_mem_read_write,
  input  logic                         in_MEM_pc_src,
  input  logic                         in_WB_mem_or_alu,
  input  logic                         in_WB_reg_write_signal,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_new_branch_pc,
  output logic                         out_zero,
  output logic [DATA_W-1:0]            out_alu_result,
  output logic [DATA_W-1:0]            out_data_2,
  output logic [REG_ADDR_W-1:0]        out_reg_write,
  output logic                         out_MEM_mem_read_write,
  output logic                         out_MEM_pc_src,
  output logic                         out_WB_mem_or_alu,
  output logic                         out_WB_reg_write_signal,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  typedef struct packed {
    logic [PC_W-1:0]       new_branch_pc;
    logic                  zero;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     data_2;
    logic [REG_ADDR_W-1:0] reg_write;
    exmem_mem_ctrl_t       mem;
    exmem_wb_ctrl_t        wb;
  } payload_t;

  localparam int PL_W  = $bits(payload_t);
  localparam int OCC_W = $clog2(DEPTH+1);

  // chain[0] is the EX input, chain[i+1] is the content of slot i.
  payload_t         chain [DEPTH+1];
  payload_t         last;
  exmem_mem_ctrl_t  mem_gated;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clear;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH:0]   feed;
  logic             free;
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_q;

  assign chain[0] = {in_new_branch_pc, in_zero, in_alu_result, in_data_2, in_reg_write,
                     in_MEM_mem_read_write, in_MEM_pc_src,
                     in_WB_mem_or_alu, in_WB_reg_write_signal};

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    exmem_slot #(.W(PL_W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[g]),
      .clear_i (clear[g]),
      .dat_i   (chain[g]),
      .vld_o   (vld[g]),
      .dat_o   (chain[g+1])
    );
  end

  always_comb begin
    free     = out_ready;
    adv      = '0;
    load     = '0;
    clear    = '0;
    vld_d    = '0;
    feed     = '0;
    occ_d    = '0;
    in_ready = 1'b0;
    // Walk from the MEM end back to EX: a slot is free if empty or its entry moves on.
    for (int i = DEPTH-1; i >= 0; i--) begin
      adv[i] = vld[i] & free;
      free   = ~vld[i] | adv[i];
    end
    in_ready = free;
    feed     = {adv, in_valid & free};
    for (int i = 0; i < DEPTH; i++) begin
      load[i]  = ~flush & feed[i];
      clear[i] = flush | (adv[i] & ~load[i]);
      vld_d[i] = load[i] | (vld[i] & ~clear[i]);
      occ_d    = occ_d + OCC_W'(vld_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign last      = chain[DEPTH];
  assign mem_gated = gate_mem(last.mem, out_valid);

  assign out_valid               = vld[DEPTH-1];
  assign out_new_branch_pc       = last.new_branch_pc;
  assign out_zero                = last.zero;
  assign out_alu_result          = last.alu_result;
  assign out_data_2              = last.data_2;
  assign out_reg_write           = last.reg_write;
  assign out_MEM_mem_read_write  = mem_gated.mem_read_write;
  assign out_MEM_pc_src          = mem_gated.pc_src;
  assign out_WB_mem_or_alu       = last.wb.mem_or_alu;
  assign out_WB_reg_write_signal = last.wb.reg_write_signal & out_valid;

endmodule

// File: tb/tb_exmem_pipe.sv
// Directed checks of exmem_pipe at DEPTH=2 and DEPTH=3, plus a random run against a scoreboard queue.
module tb_exmem_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] pc;
  logic        zero;
  logic [7:0]  alu;
  logic [7:0]  d2;
  logic [2:0]  rw;
  logic        mrw, psrc, moa, wbrw;

  logic        iv2, ir2, f2, or2, ov2, oz2, omrw2, opsrc2, omoa2, owbrw2;
  logic [11:0] opc2;
  logic [7:0]  oalu2, od22;
  logic [2:0]  orw2;
  logic [1:0]  occ2;

  logic        iv3, ir3, f3, or3, ov3, oz3, omrw3, opsrc3, omoa3, owbrw3;
  logic [11:0] opc3;
  logic [7:0]  oalu3, od23;
  logic [2:0]  orw3;
  logic [1:0]  occ3;

  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  exmem_pipe #(.DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(f2), .in_valid(iv2), .in_ready(ir2),
    .in_new_branch_pc(pc), .in_zero(zero), .in_alu_result(alu), .in_data_2(d2),
    .in_reg_write(rw), .in_MEM_mem_read_write(mrw), .in_MEM_pc_src(psrc),
    .in_WB_mem_or_alu(moa), .in_WB_reg_write_signal(wbrw),
    .out_valid(ov2), .out_ready(or2), .out_new_branch_pc(opc2), .out_zero(oz2),
    .out_alu_result(oalu2), .out_data_2(od22), .out_reg_write(orw2),
    .out_MEM_mem_read_write(omrw2), .out_MEM_pc_src(opsrc2),
    .out_WB_mem_or_alu(omoa2), .out_WB_reg_write_signal(owbrw2), .occupancy(occ2)
  );

  exmem_pipe #(.DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(f3), .in_valid(iv3), .in_ready(ir3),
    .in_new_branch_pc(pc), .in_zero(zero), .in_alu_result(alu), .in_data_2(d2),
    .in_reg_write(rw), .in_MEM_mem_read_write(mrw), .in_MEM_pc_src(psrc),
    .in_WB_mem_or_alu(moa), .in_WB_reg_write_signal(wbrw),
    .out_valid(ov3), .out_ready(or3), .out_new_branch_pc(opc3), .out_zero(oz3),
    .out_alu_result(oalu3), .out_data_2(od23), .out_reg_write(orw3),
    .out_MEM_mem_read_write(omrw3), .out_MEM_pc_src(opsrc3),
    .out_WB_mem_or_alu(omoa3), .out_WB_reg_write_signal(owbrw3), .occupancy(occ3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    {pc, zero, alu, d2, rw, mrw, psrc, moa, wbrw} = '0;
    {iv2, f2, or2, iv3, f3, or3} = '0;
    #1;
    chk("rst_occ2", 32'(occ2), 32'd0);
    chk("rst_ov2", 32'(ov2), 32'd0);
    chk("rst_ir2", 32'(ir2), 32'd1);
    chk("rst_occ3", 32'(occ3), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill DUT2 under stall, then reset asynchronously mid-stream.
    iv2 = 1'b1; or2 = 1'b0;
    alu = 8'h5A; pc = 12'hABC; d2 = 8'h3C; rw = 3'd5; zero = 1'b1;
    {mrw, psrc, moa, wbrw} = 4'b1111;
    step();
    step();
    iv2 = 1'b0;
    #1;
    chk("full_occ2", 32'(occ2), 32'd2);
    chk("full_ov2", 32'(ov2), 32'd1);
    chk("full_ir2", 32'(ir2), 32'd0);
    chk("full_pc2", 32'(opc2), 32'hABC);
    chk("full_mrw2", 32'(omrw2), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov2", 32'(ov2), 32'd0);
    chk("mid_rst_alu2", 32'(oalu2), 32'd0);
    chk("mid_rst_pc2", 32'(opc2), 32'd0);
    chk("mid_rst_wbrw2", 32'(owbrw2), 32'd0);
    chk("mid_rst_mrw2", 32'(omrw2), 32'd0);
    chk("mid_rst_occ2", 32'(occ2), 32'd0);
    chk("mid_rst_ir2", 32'(ir2), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at DEPTH=2: out appears exactly two cycles after in.
    or2 = 1'b1; iv2 = 1'b1; alu = 8'h11;
    #1 chk("strm_c0_ov", 32'(ov2), 32'd0);
    step(); alu = 8'h22;
    #1 chk("strm_c1_ov", 32'(ov2), 32'd0);
    step(); alu = 8'h33;
    #1 chk("strm_c2_ov", 32'(ov2), 32'd1);
    chk("strm_c2_alu", 32'(oalu2), 32'h11);
    step(); iv2 = 1'b0;
    #1 chk("strm_c3_ov", 32'(ov2), 32'd1);
    chk("strm_c3_alu", 32'(oalu2), 32'h22);
    step();
    #1 chk("strm_c4_ov", 32'(ov2), 32'd1);
    chk("strm_c4_alu", 32'(oalu2), 32'h33);
    chk("strm_c4_occ", 32'(occ2), 32'd1);
    chk("strm_c4_mrw", 32'(omrw2), 32'd1);
    step();
    #1 chk("gate_ov", 32'(ov2), 32'd0);
    chk("gate_mrw", 32'(omrw2), 32'd0);
    chk("gate_psrc", 32'(opsrc2), 32'd0);
    chk("gate_wbrw", 32'(owbrw2), 32'd0);
    chk("gate_occ", 32'(occ2), 32'd0);

    // Stall and bubble collapse at DEPTH=3.
    or3 = 1'b1; iv3 = 1'b1; alu = 8'hA5;
    step(); iv3 = 1'b0; or3 = 1'b0;
    step(); iv3 = 1'b1; alu = 8'hB6;
    #1 chk("col_ir_b6", 32'(ir3), 32'd1);
    step(); alu = 8'hC7;
    #1 chk("col_ir_c7", 32'(ir3), 32'd1);
    step(); iv3 = 1'b0;
    #1 chk("col_occ_full", 32'(occ3), 32'd3);
    chk("col_ir_full", 32'(ir3), 32'd0);
    chk("col_head_a5", 32'(oalu3), 32'hA5);
    step();
    #1 chk("col_hold_occ", 32'(occ3), 32'd3);
    chk("col_hold_ov", 32'(ov3), 32'd1);
    or3 = 1'b1;
    #1 chk("col_ir_drain", 32'(ir3), 32'd1);
    chk("col_out0", 32'(oalu3), 32'hA5);
    step();
    #1 chk("col_out1", 32'(oalu3), 32'hB6);
    chk("col_out1_ov", 32'(ov3), 32'd1);
    step();
    #1 chk("col_out2", 32'(oalu3), 32'hC7);
    chk("col_out2_ov", 32'(ov3), 32'd1);
    step();
    #1 chk("col_empty_ov", 32'(ov3), 32'd0);
    chk("col_empty_occ", 32'(occ3), 32'd0);

    // Flush with a simultaneous input offer at DEPTH=2.
    or2 = 1'b0; iv2 = 1'b1; wbrw = 1'b1; alu = 8'h01;
    step(); alu = 8'h02;
    step();
    #1 chk("fl_pre_occ", 32'(occ2), 32'd2);
    chk("fl_pre_wbrw", 32'(owbrw2), 32'd1);
    f2 = 1'b1; alu = 8'h44; or2 = 1'b1;
    step(); f2 = 1'b0; iv2 = 1'b0;
    #1 chk("fl_occ", 32'(occ2), 32'd0);
    chk("fl_ov", 32'(ov2), 32'd0);
    chk("fl_wbrw", 32'(owbrw2), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      #1 chk("fl_no44", 32'(ov2), 32'd0);
    end

    // Random traffic at DEPTH=3 against a queue of accepted, not yet delivered entries.
    q.delete();
    for (int n = 0; n < 10000; n++) begin
      iv3  = ($urandom_range(0, 3) != 0);
      or3  = 1'($urandom_range(0, 1));
      f3   = ($urandom_range(0, 63) == 0);
      alu  = 8'($urandom);
      d2   = ~alu;
      mrw  = 1'($urandom_range(0, 1));
      psrc = 1'($urandom_range(0, 1));
      wbrw = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_occ", 32'(occ3), 32'(q.size()));
      chk("rnd_ir", 32'(ir3), 32'(!(q.size() == 3 && !or3)));
      if (!ov3) chk("rnd_bubble_ctrl", 32'({omrw3, opsrc3, owbrw3}), 32'd0);
      if (ov3 && or3) begin
        if (q.size() == 0) chk("rnd_spurious_out", 32'(ov3), 32'd0);
        else chk("rnd_order", 32'({oalu3, od23}), 32'(q[0]));
      end
      if (f3) begin
        q.delete();
      end else begin
        if (ov3 && or3 && q.size() > 0) void'(q.pop_front());
        if (iv3 && ir3) q.push_back({alu, d2});
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
